// File: rtl/stack_pkg.sv
// Shared opcode and FSM state definitions for the stack sequencer.
package stack_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_PEEK = 3'd3;
  localparam logic [2:0] OP_DUP  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SWAP2,
    S_RESP
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer driving a Stack_Memory port; one response per accepted request.
// Define STACK_CTRL_HWM_EN to add the hwm (high-water-mark) output.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [2:0]           op_code,
  input  logic [DATA_W-1:0]    op_data,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic [ADDR_BITS-1:0] count,
  output logic                 StackWrite,
  output logic [ADDR_BITS-1:0] SP,
  output logic [DATA_W-1:0]    write_data,
  input  logic [DATA_W-1:0]    read1,
  input  logic [DATA_W-1:0]    read2
`ifdef STACK_CTRL_HWM_EN
  ,
  output logic [ADDR_BITS-1:0] hwm
`endif
);

  localparam logic [ADDR_BITS-1:0] FULL = '1;
  localparam logic [ADDR_BITS-1:0] ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] TWO  = ADDR_BITS'(2);

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  err_q, err_d;
  logic [ADDR_BITS-1:0]  count_q, count_d;
  logic [ADDR_BITS-1:0]  sp_q, sp_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  accept;
  logic                  req_err;

  assign accept = op_valid && (state_q == S_IDLE);

  always_comb begin
    req_err = 1'b0;
    case (op_code)
      OP_NOP:           req_err = 1'b0;
      OP_PUSH:          req_err = (count_q == FULL);
      OP_POP, OP_PEEK:  req_err = (count_q == '0);
      OP_DUP:           req_err = (count_q == FULL) || (count_q == '0);
      OP_SWAP:          req_err = (count_q < TWO);
      default:          req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    err_d       = err_q;
    count_d     = count_q;
    sp_d        = sp_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXEC;
          op_d    = op_code;
          err_d   = req_err;
          if (!req_err) begin
            case (op_code)
              OP_PUSH: begin
                sp_d    = count_q;
                we_d    = 1'b1;
                wdata_d = op_data;
              end
              OP_POP, OP_PEEK: sp_d = count_q - ONE;
              OP_DUP: begin
                sp_d = count_q;
                we_d = 1'b1;
              end
              OP_SWAP: begin
                sp_d = count_q - ONE;
                we_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      S_EXEC: begin
        we_d        = 1'b0;
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_data_d  = '0;
        if (!err_q) begin
          case (op_q)
            OP_PUSH: count_d = count_q + ONE;
            OP_POP: begin
              rsp_data_d = read1;
              count_d    = count_q - ONE;
            end
            OP_PEEK: rsp_data_d = read1;
            OP_DUP: begin
              rsp_data_d = read2;
              count_d    = count_q + ONE;
            end
            OP_SWAP: begin
              // wdata_q doubles as the swap temporary holding the old top
              rsp_data_d  = read2;
              wdata_d     = read1;
              sp_d        = count_q - TWO;
              we_d        = 1'b1;
              rsp_valid_d = 1'b0;
              state_d     = S_SWAP2;
            end
            default: ;
          endcase
        end
      end
      S_SWAP2: begin
        we_d        = 1'b0;
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
      end
      S_RESP: begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      err_q       <= 1'b0;
      count_q     <= '0;
      sp_q        <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      err_q       <= err_d;
      count_q     <= count_d;
      sp_q        <= sp_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // DUP and SWAP write the word read back through read2 during EXEC
  assign write_data = (state_q == S_EXEC && !err_q && (op_q == OP_DUP || op_q == OP_SWAP))
                      ? read2 : wdata_q;

  assign op_ready   = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign count      = count_q;
  assign StackWrite = we_q;
  assign SP         = sp_q;

`ifdef STACK_CTRL_HWM_EN
  logic [ADDR_BITS-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (count_q > hwm_q) hwm_d = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized self-checking bench for stack_ctrl: a 5-bit and a 2-bit instance, each with a
// behavioural memory, compared against a queue-based stack model.
module tb_stack_ctrl;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_data = 32'd0;

  logic        op_valid_a, op_ready_a, rsp_valid_a, rsp_err_a, we_a;
  logic [31:0] rsp_data_a, wd_a, rd1_a, rd2_a;
  logic [4:0]  count_a, sp_a;
  logic        op_valid_b, op_ready_b, rsp_valid_b, rsp_err_b, we_b;
  logic [31:0] rsp_data_b, wd_b, rd1_b, rd2_b;
  logic [1:0]  count_b, sp_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [4];

  assign op_valid_a = op_valid & ~sel;
  assign op_valid_b = op_valid & sel;
  assign rd1_a = mem_a[sp_a];
  assign rd2_a = mem_a[sp_a - 5'd1];
  assign rd1_b = mem_b[sp_b];
  assign rd2_b = mem_b[sp_b - 2'd1];

  always @(posedge clk) if (we_a) mem_a[sp_a] <= wd_a;
  always @(posedge clk) if (we_b) mem_b[sp_b] <= wd_b;

`ifdef STACK_CTRL_HWM_EN
  logic [4:0] hwm_a;
  logic [1:0] hwm_b;
  logic [4:0] hwm_s;
  assign hwm_s = sel ? {3'b0, hwm_b} : hwm_a;
`endif

  stack_ctrl #(.DATA_W(32), .ADDR_BITS(5)) u_dut_a (
    .clk(clk), .reset(reset), .op_valid(op_valid_a), .op_ready(op_ready_a),
    .op_code(op_code), .op_data(op_data), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .rsp_err(rsp_err_a), .count(count_a), .StackWrite(we_a), .SP(sp_a),
    .write_data(wd_a), .read1(rd1_a), .read2(rd2_a)
`ifdef STACK_CTRL_HWM_EN
    , .hwm(hwm_a)
`endif
  );

  stack_ctrl #(.DATA_W(32), .ADDR_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset), .op_valid(op_valid_b), .op_ready(op_ready_b),
    .op_code(op_code), .op_data(op_data), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .rsp_err(rsp_err_b), .count(count_b), .StackWrite(we_b), .SP(sp_b),
    .write_data(wd_b), .read1(rd1_b), .read2(rd2_b)
`ifdef STACK_CTRL_HWM_EN
    , .hwm(hwm_b)
`endif
  );

  logic        ready_s, rv_s, re_s, we_s;
  logic [31:0] rd_s, wd_s;
  logic [4:0]  cnt_s, sp_s;

  always_comb begin
    if (sel) begin
      ready_s = op_ready_b; rv_s = rsp_valid_b; re_s = rsp_err_b; we_s = we_b;
      rd_s = rsp_data_b; wd_s = wd_b; cnt_s = {3'b0, count_b}; sp_s = {3'b0, sp_b};
    end else begin
      ready_s = op_ready_a; rv_s = rsp_valid_a; re_s = rsp_err_a; we_s = we_a;
      rd_s = rsp_data_a; wd_s = wd_a; cnt_s = count_a; sp_s = sp_a;
    end
  end

  int wr_cnt = 0;
  int bad_wr = 0;
  always @(posedge clk) begin
    if (we_s) begin
      wr_cnt = wr_cnt + 1;
      if (sp_s == (sel ? 5'd3 : 5'd31)) bad_wr = bad_wr + 1;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] mdl_a[$];
  logic [31:0] mdl_b[$];
  int          hwm_m [2];

  function automatic logic [31:0] mem_rd(input int i);
    logic [4:0] ia;
    logic [1:0] ib;
    ia = i[4:0];
    ib = i[1:0];
    return sel ? mem_b[ib] : mem_a[ia];
  endfunction

  task automatic do_op(input logic [2:0] code, input logic [31:0] d);
    logic [31:0] q[$];
    int          cap, n, exp_wr, exp_lat, lat;
    logic [31:0] exp_d, got_d;
    logic        exp_e, got_e, seen;
    q = sel ? mdl_b : mdl_a;
    cap = sel ? 3 : 31;
    n = q.size();
    exp_d = 32'd0; exp_e = 1'b0; exp_wr = 0;
    got_d = 32'd0; got_e = 1'b0;
    case (code)
      OP_NOP: ;
      OP_PUSH: if (n == cap) exp_e = 1'b1; else begin q.push_back(d); exp_wr = 1; end
      OP_POP:  if (n == 0) exp_e = 1'b1; else exp_d = q.pop_back();
      OP_PEEK: if (n == 0) exp_e = 1'b1; else exp_d = q[n-1];
      OP_DUP:  if (n == 0 || n == cap) exp_e = 1'b1;
               else begin exp_d = q[n-1]; q.push_back(exp_d); exp_wr = 1; end
      OP_SWAP: if (n < 2) exp_e = 1'b1;
               else begin exp_d = q[n-2]; q[n-2] = q[n-1]; q[n-1] = exp_d; exp_wr = 2; end
      default: exp_e = 1'b1;
    endcase
    exp_lat = (code == OP_SWAP && !exp_e) ? 3 : 2;

    @(negedge clk);
    op_code = code; op_data = d; op_valid = 1'b1;
    check_val("op_ready", ready_s, 1'b1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    wr_cnt = 0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (rv_s) begin seen = 1'b1; got_d = rd_s; got_e = re_s; end
    end
    check_val("rsp_seen", seen, 1'b1);
    check_val("latency", lat, exp_lat);
    check_val("rsp_data", got_d, exp_d);
    check_val("rsp_err", got_e, exp_e);
    @(negedge clk);
    check_val("rsp_pulse", rv_s, 1'b0);
    check_val("err_clear", re_s, 1'b0);
    check_val("writes", wr_cnt, exp_wr);
    check_val("count", cnt_s, q.size());
    for (int i = 0; i < q.size(); i++) check_val("mem", mem_rd(i), q[i]);
    if (q.size() > hwm_m[sel]) hwm_m[sel] = q.size();
`ifdef STACK_CTRL_HWM_EN
    check_val("hwm", hwm_s, hwm_m[sel]);
`endif
    if (sel) mdl_b = q; else mdl_a = q;
  endtask

  task automatic rand_op();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: do_op(OP_PUSH, $urandom());
      4: do_op(OP_POP, 32'd0);
      5: do_op(OP_PEEK, 32'd0);
      6: do_op(OP_DUP, 32'd0);
      7: do_op(OP_SWAP, 32'd0);
      8: do_op(OP_NOP, $urandom());
      default: do_op(($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7, $urandom());
    endcase
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_a[i] = 32'd0;
    for (int i = 0; i < 4; i++) mem_b[i] = 32'd0;
    hwm_m[0] = 0; hwm_m[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_count", cnt_s, 5'd0);
    check_val("rst_rsp_valid", rv_s, 1'b0);
    check_val("rst_rsp_data", rd_s, 32'd0);
    check_val("rst_rsp_err", re_s, 1'b0);
    check_val("rst_we", we_s, 1'b0);
    check_val("rst_sp", sp_s, 5'd0);
    check_val("rst_wdata", wd_s, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(OP_PUSH, 32'd7); do_op(OP_PUSH, 32'd4); do_op(OP_PUSH, 32'd3);
    repeat (4) do_op(OP_POP, 32'd0);
    do_op(OP_PUSH, 32'd5); do_op(OP_PUSH, 32'd9); do_op(OP_SWAP, 32'd0); do_op(OP_PEEK, 32'd0);
    do_op(OP_POP, 32'd0); do_op(OP_POP, 32'd0);
    do_op(OP_PUSH, 32'd2); do_op(OP_DUP, 32'd0); do_op(OP_POP, 32'd0); do_op(OP_SWAP, 32'd0);
    do_op(OP_DUP, 32'd0); do_op(OP_NOP, 32'd99);

    sel = 1'b1;
    do_op(OP_PUSH, 32'd1); do_op(OP_PUSH, 32'd2); do_op(OP_PUSH, 32'd3);
    do_op(OP_PUSH, 32'd4); do_op(OP_DUP, 32'd0); do_op(3'd6, 32'd0); do_op(3'd7, 32'd0);
    do_op(OP_SWAP, 32'd0);
    for (int k = 0; k < 60; k++) rand_op();
    sel = 1'b0;

    do_op(OP_PUSH, 32'd11); do_op(OP_PUSH, 32'd22); do_op(OP_PUSH, 32'd33);
`ifdef STACK_CTRL_HWM_EN
    check_val("hwm_pre", hwm_s, hwm_m[0]);
`endif
    @(negedge clk);
    op_code = OP_SWAP; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk);
    #2;
    check_val("swap2_we", we_s, 1'b1);
    check_val("swap2_sp", sp_s, mdl_a.size() - 2);
    reset = 1'b1;
    #1;
    check_val("arst_we", we_s, 1'b0);
    check_val("arst_count", cnt_s, 5'd0);
    check_val("arst_rsp_valid", rv_s, 1'b0);
    mdl_a.delete(); mdl_b.delete();
    hwm_m[0] = 0; hwm_m[1] = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("arst_ready", ready_s, 1'b1);
`ifdef STACK_CTRL_HWM_EN
    check_val("hwm_post", hwm_s, 5'd0);
`endif

    for (int k = 0; k < 300; k++) rand_op();
    check_val("no_write_top_addr", bad_wr, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
